// File: rtl/mem_responder.sv
// Single-port-style backing store for the cache read/write request interface.
// One transfer at a time, fixed latency, 4-phase ack; write wins over read.
module mem_responder #(
  parameter int ADDR_W = 32,
  parameter int MEM_B  = 16,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [1:0]        rlen,
  output logic              rack,
  output logic [31:0]       dout,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [1:0]        wlen,
  input  logic [31:0]       din,
  output logic              wack,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, RD, WR, RACK, WACK} state_t;

  localparam int unsigned DEPTH = 1 << MEM_B;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [MEM_B-1:0]   addr_q, addr_d;
  logic [1:0]         len_q, len_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        dout_q, dout_d;
  logic               rack_q, rack_d;
  logic               wack_q, wack_d;
  logic               busy_q, busy_d;
  logic               mem_we;

  logic [7:0]         mem [DEPTH];
  logic [MEM_B-1:0]   byte_addr [4];
  logic [31:0]        rd_word;

  // Only the low MEM_B address bits select a byte; the rest are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr[ADDR_W-1:MEM_B], waddr[ADDR_W-1:MEM_B]};

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      byte_addr[k] = addr_q + MEM_B'(k);
    end
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (2'(k) <= len_q) rd_word[8*k +: 8] = mem[byte_addr[k]];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    rack_d  = rack_q;
    wack_d  = wack_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (we) begin
          addr_d  = waddr[MEM_B-1:0];
          len_d   = wlen;
          wdata_d = din;
          cnt_d   = 4'(LAT - 1);
          state_d = WR;
        end else if (re) begin
          addr_d  = raddr[MEM_B-1:0];
          len_d   = rlen;
          cnt_d   = 4'(LAT - 1);
          state_d = RD;
        end
      end
      RD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          dout_d  = rd_word;
          rack_d  = 1'b1;
          state_d = RACK;
        end
      end
      WR: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we  = 1'b1;
          wack_d  = 1'b1;
          state_d = WACK;
        end
      end
      RACK: begin
        if (!re) begin
          rack_d  = 1'b0;
          state_d = IDLE;
        end
      end
      WACK: begin
        if (!we) begin
          wack_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      rack_q  <= 1'b0;
      wack_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      rack_q  <= rack_d;
      wack_q  <= wack_d;
      busy_q  <= busy_d;
    end
  end

  // Storage survives rst; a write abandoned by rst never reaches mem_we.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (2'(k) <= len_q) mem[byte_addr[k]] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign rack = rack_q;
  assign wack = wack_q;
  assign dout = dout_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: two instances (LAT=2 and LAT=4) share the
// request inputs; sel picks which instance the handshake tasks follow.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        re, we;
  logic [31:0] raddr, waddr, din;
  logic [1:0]  rlen, wlen;
  logic        rack_a, wack_a, busy_a, rack_b, wack_b, busy_b;
  logic [31:0] dout_a, dout_b;
  logic        sel;
  logic        rack_s, wack_s, busy_s;
  logic [31:0] dout_s;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign rack_s = sel ? rack_b : rack_a;
  assign wack_s = sel ? wack_b : wack_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign dout_s = sel ? dout_b : dout_a;

  mem_responder #(.ADDR_W(32), .MEM_B(16), .LAT(2)) dut_a (
    .clk(clk), .rst(rst), .re(re), .raddr(raddr), .rlen(rlen), .rack(rack_a),
    .dout(dout_a), .we(we), .waddr(waddr), .wlen(wlen), .din(din),
    .wack(wack_a), .busy(busy_a)
  );

  mem_responder #(.ADDR_W(32), .MEM_B(16), .LAT(4)) dut_b (
    .clk(clk), .rst(rst), .re(re), .raddr(raddr), .rlen(rlen), .rack(rack_b),
    .dout(dout_b), .we(we), .waddr(waddr), .wlen(wlen), .din(din),
    .wack(wack_b), .busy(busy_b)
  );

  task automatic do_write(input logic [31:0] a, input logic [1:0] l,
                          input logic [31:0] d, input int exp_lat, input string nm);
    int n;
    n = -1;
    waddr = a; wlen = l; din = d; we = 1'b1;
    do begin
      @(posedge clk); @(negedge clk); n++;
      if (n == 0) begin
        waddr = ~a; wlen = ~l; din = ~d;
      end
    end while (wack_s !== 1'b1 && n < 20);
    checks++;
    if (n !== exp_lat) begin
      failures++;
      $display("FAIL %s wack_latency got=%0d exp=%0d", nm, n, exp_lat);
    end
    we = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (wack_s !== 1'b0 || busy_s !== 1'b0) begin
      failures++;
      $display("FAIL %s wack_fall got wack=%b busy=%b exp 0 0", nm, wack_s, busy_s);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] l,
                         input logic [31:0] exp_d, input int exp_lat, input string nm);
    int n;
    n = -1;
    raddr = a; rlen = l; re = 1'b1;
    do begin
      @(posedge clk); @(negedge clk); n++;
      if (n == 0) begin
        raddr = ~a; rlen = ~l;
      end
    end while (rack_s !== 1'b1 && n < 20);
    checks++;
    if (n !== exp_lat || dout_s !== exp_d) begin
      failures++;
      $display("FAIL %s read got lat=%0d dout=%08h exp lat=%0d dout=%08h",
               nm, n, dout_s, exp_lat, exp_d);
    end
    re = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (rack_s !== 1'b0 || busy_s !== 1'b0 || dout_s !== exp_d) begin
      failures++;
      $display("FAIL %s rack_fall got rack=%b busy=%b dout=%08h exp 0 0 %08h",
               nm, rack_s, busy_s, dout_s, exp_d);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    re = 1'b0; we = 1'b0; raddr = '0; waddr = '0; din = '0; rlen = '0; wlen = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rack_a, wack_a, busy_a, dout_a} !== 35'd0 || {rack_b, wack_b, busy_b, dout_b} !== 35'd0) begin
      failures++;
      $display("FAIL reset_values got a=%b%b%b/%08h b=%b%b%b/%08h exp all zero",
               rack_a, wack_a, busy_a, dout_a, rack_b, wack_b, busy_b, dout_b);
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({rack_a, wack_a, busy_a, dout_a} !== 35'd0) begin
      failures++;
      $display("FAIL idle_after_reset got %b%b%b/%08h exp all zero", rack_a, wack_a, busy_a, dout_a);
    end
  endtask

  task automatic test_write_read();
    do_write(32'h100, 2'd3, 32'hDEADBEEF, 2, "wr_deadbeef");
    do_read(32'h100, 2'd3, 32'hDEADBEEF, 2, "rd_deadbeef");
  endtask

  task automatic test_byte_merge();
    do_write(32'h200, 2'd3, 32'h11223344, 2, "wr_word");
    do_write(32'h202, 2'd0, 32'hBBCCDDAA, 2, "wr_byte");
    do_read(32'h200, 2'd3, 32'h11AA3344, 2, "rd_merged");
    do_read(32'h201, 2'd1, 32'h0000AA33, 2, "rd_half_misaligned");
    do_read(32'h200, 2'd2, 32'h00AA3344, 2, "rd_three_bytes");
  endtask

  task automatic test_priority();
    int  n;
    logic rack_seen;
    rack_seen = 1'b0;
    waddr = 32'h40; wlen = 2'd3; din = 32'h5;
    raddr = 32'h40; rlen = 2'd3;
    we = 1'b1; re = 1'b1;
    n = -1;
    do begin
      @(posedge clk); @(negedge clk); n++;
      if (rack_s !== 1'b0) rack_seen = 1'b1;
    end while (wack_s !== 1'b1 && n < 20);
    checks++;
    if (n !== 2 || rack_seen) begin
      failures++;
      $display("FAIL prio_write_first got lat=%0d rack_seen=%b exp 2 0", n, rack_seen);
    end
    we = 1'b0;
    n = 0;
    do begin
      @(posedge clk); @(negedge clk); n++;
    end while (rack_s !== 1'b1 && n < 20);
    checks++;
    if (n !== 4 || dout_s !== 32'h5) begin
      failures++;
      $display("FAIL prio_read_after got cycles=%0d dout=%08h exp 4 00000005", n, dout_s);
    end
    re = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_wrap();
    do_write(32'hFFFE, 2'd3, 32'hCAFEF00D, 2, "wr_wrap");
    do_read(32'h0000, 2'd1, 32'h0000CAFE, 2, "rd_wrap_low");
    do_read(32'hFFFE, 2'd3, 32'hCAFEF00D, 2, "rd_wrap_word");
    do_read(32'hFFFF, 2'd0, 32'h000000F0, 2, "rd_top_byte");
    do_read(32'h12340001, 2'd0, 32'h000000CA, 2, "rd_high_bits_ignored");
  endtask

  task automatic test_hold_ack();
    int n;
    logic bad;
    bad = 1'b0;
    raddr = 32'h100; rlen = 2'd3; re = 1'b1;
    n = -1;
    do begin
      @(posedge clk); @(negedge clk); n++;
    end while (rack_s !== 1'b1 && n < 20);
    checks++;
    if (n !== 2 || dout_s !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL hold_rack_rise got lat=%0d dout=%08h exp 2 deadbeef", n, dout_s);
    end
    waddr = 32'h300; wlen = 2'd0; din = 32'h77; we = 1'b1;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      if (rack_s !== 1'b1 || wack_s !== 1'b0 || dout_s !== 32'hDEADBEEF) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL hold_rack_stable got rack=%b wack=%b dout=%08h exp 1 0 deadbeef",
               rack_s, wack_s, dout_s);
    end
    re = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (rack_s !== 1'b0 || busy_s !== 1'b0 || dout_s !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL hold_rack_fall got rack=%b busy=%b dout=%08h exp 0 0 deadbeef",
               rack_s, busy_s, dout_s);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (busy_s !== 1'b1 || wack_s !== 1'b0) begin
      failures++;
      $display("FAIL hold_write_accept got busy=%b wack=%b exp 1 0", busy_s, wack_s);
    end
    n = 0;
    do begin
      @(posedge clk); @(negedge clk); n++;
    end while (wack_s !== 1'b1 && n < 20);
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL hold_write_latency got=%0d exp=2", n);
    end
    we = 1'b0;
    @(posedge clk); @(negedge clk);
    do_read(32'h300, 2'd0, 32'h00000077, 2, "rd_after_hold");
  endtask

  task automatic test_reset_midop();
    sel = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_write(32'h80, 2'd3, 32'h0, 4, "b_wr_zero");
    waddr = 32'h80; wlen = 2'd3; din = 32'h12345678; we = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rack_b !== 1'b0 || wack_b !== 1'b0 || busy_b !== 1'b0 || dout_b !== 32'h0) begin
      failures++;
      $display("FAIL midop_reset_outputs got rack=%b wack=%b busy=%b dout=%08h exp 0 0 0 0",
               rack_b, wack_b, busy_b, dout_b);
    end
    we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_read(32'h80, 2'd3, 32'h00000000, 4, "b_rd_abandoned");
    do_write(32'h84, 2'd1, 32'h0000BEEF, 4, "b_wr_half");
    do_read(32'h84, 2'd1, 32'h0000BEEF, 4, "b_rd_half");
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_merge();
    test_priority();
    test_wrap();
    test_hold_ack();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

endmodule
